// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the DLX pipeline.
//   Owns the PC and issues one outstanding request at a time to instruction
//   memory (req/ready handshake, req+addr held stable until ready).
//   Fetched words go to decode through a registered valid interface, backed
//   by a one-entry skid buffer so that a stalled decode loses nothing.
//   A redirect (branch taken or jump) flushes the wrong-path word and restarts
//   fetch at new_pc_in. A request already in flight is drained first because
//   requests cannot be aborted.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall_in                   decode holds its current input
//   branch_taken_in/jmp_inst_in/new_pc_in   redirect from decode/control
//   imem_req_out/imem_addr_out/imem_ready_in/imem_data_in   memory port
//   inst_out/npc_out/inst_valid_out         decode-side output
module instr_fetch #(
  parameter int                     PC_WIDTH   = 32,
  parameter int                     INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
  parameter int                     PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic                  branch_taken_in,
  input  logic                  jmp_inst_in,
  input  logic [PC_WIDTH-1:0]   new_pc_in,
  output logic                  imem_req_out,
  output logic [PC_WIDTH-1:0]   imem_addr_out,
  input  logic                  imem_ready_in,
  input  logic [INST_WIDTH-1:0] imem_data_in,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   npc_out,
  output logic                  inst_valid_out
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  // BUFFERED doubles as the skid-buffer occupancy flag.
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, BUFFERED} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc_target_q, pc_target_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [PC_WIDTH-1:0]   skid_npc_q, skid_npc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [PC_WIDTH-1:0]   npc_q, npc_d;
  logic                  valid_q, valid_d;

  logic                  redirect;
  logic [PC_WIDTH-1:0]   pc_inc;

  assign redirect = branch_taken_in | jmp_inst_in;
  assign pc_inc   = pc_q + STEP;  // wraps modulo 2^PC_WIDTH

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_target_d = pc_target_q;
    skid_inst_d = skid_inst_q;
    skid_npc_d  = skid_npc_q;
    inst_d      = inst_q;
    npc_d       = npc_q;
    // Decode consumes the current word unless stalled.
    valid_d     = valid_q & stall_in;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (imem_ready_in) begin
            pc_d = new_pc_in;
          end else begin
            // Request is in flight and cannot be dropped: remember target.
            pc_target_d = new_pc_in;
            state_d     = DRAIN;
          end
        end else if (imem_ready_in) begin
          pc_d = pc_inc;
          if (!valid_q || !stall_in) begin
            inst_d  = imem_data_in;
            npc_d   = pc_inc;
            valid_d = 1'b1;
          end else begin
            skid_inst_d = imem_data_in;
            skid_npc_d  = pc_inc;
            state_d     = BUFFERED;
          end
        end
      end

      DRAIN: begin
        if (redirect) begin
          valid_d     = 1'b0;
          pc_target_d = new_pc_in;
        end
        if (imem_ready_in) begin
          // Returned word is wrong-path; the latest target wins.
          pc_d    = redirect ? new_pc_in : pc_target_q;
          state_d = FETCH;
        end
      end

      BUFFERED: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = new_pc_in;
          state_d = FETCH;
        end else if (!stall_in) begin
          inst_d  = skid_inst_q;
          npc_d   = skid_npc_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_target_q <= '0;
      skid_inst_q <= '0;
      skid_npc_q  <= '0;
      inst_q      <= '0;
      npc_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_target_q <= pc_target_d;
      skid_inst_q <= skid_inst_d;
      skid_npc_q  <= skid_npc_d;
      inst_q      <= inst_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
    end
  end

  // In DRAIN pc_q still holds the in-flight address, so addr stays stable.
  assign imem_req_out   = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr_out  = pc_q;
  assign inst_out       = inst_q;
  assign npc_out        = npc_q;
  assign inst_valid_out = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small instruction-memory model with a
// programmable wait count answers requests; each task walks one scenario
// cycle by cycle and compares outputs at the falling edge.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic        jmp_inst_in = 1'b0;
  logic [31:0] new_pc_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in = 1'b0;
  logic [31:0] imem_data_in = '0;
  logic [31:0] inst_out;
  logic [31:0] npc_out;
  logic        inst_valid_out;

  int nvec = 0;
  int nerr = 0;
  int mem_wait = 0;
  int wait_cnt = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .branch_taken_in(branch_taken_in), .jmp_inst_in(jmp_inst_in),
    .new_pc_in(new_pc_in), .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out), .imem_ready_in(imem_ready_in),
    .imem_data_in(imem_data_in), .inst_out(inst_out), .npc_out(npc_out),
    .inst_valid_out(inst_valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   memword = 32'h20010005;
      32'h4:   memword = 32'h20020007;
      32'h8:   memword = 32'h00221820;
      default: memword = a ^ 32'hDEAD0000;
    endcase
  endfunction

  // Memory model: answers after mem_wait cycles of a pending request.
  task automatic mem_drive();
    if (imem_req_out) begin
      if (wait_cnt >= mem_wait) begin
        imem_ready_in = 1'b1;
        imem_data_in  = memword(imem_addr_out);
        wait_cnt      = 0;
      end else begin
        imem_ready_in = 1'b0;
        imem_data_in  = '0;
        wait_cnt++;
      end
    end else begin
      imem_ready_in = 1'b0;
      imem_data_in  = '0;
    end
  endtask

  // Advance one clock; return at the falling edge with memory inputs set.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    mem_drive();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0; jmp_inst_in = 1'b0;
    new_pc_in = '0; imem_ready_in = 1'b0; imem_data_in = '0; wait_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_drive();
  endtask

  task automatic test_reset();
    mem_wait = 0;
    apply_reset();
    nvec++; if (imem_req_out !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", imem_req_out); end
    nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", inst_valid_out); end
    nvec++; if (inst_out !== 32'h0) begin nerr++; $display("FAIL rst_inst got %h want 0", inst_out); end
    nvec++; if (npc_out !== 32'h0) begin nerr++; $display("FAIL rst_npc got %h want 0", npc_out); end
    nvec++; if (imem_addr_out !== 32'h0) begin nerr++; $display("FAIL rst_addr got %h want 0", imem_addr_out); end
    cyc();
    nvec++; if (imem_req_out !== 1'b1) begin nerr++; $display("FAIL zw_req1 got %b want 1", imem_req_out); end
    nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL zw_valid1 got %b want 0", inst_valid_out); end
    cyc();
    nvec++; if (inst_valid_out !== 1'b1) begin nerr++; $display("FAIL zw_valid2 got %b want 1", inst_valid_out); end
    nvec++; if (inst_out !== 32'h20010005) begin nerr++; $display("FAIL zw_inst2 got %h want 20010005", inst_out); end
    nvec++; if (npc_out !== 32'h4) begin nerr++; $display("FAIL zw_npc2 got %h want 4", npc_out); end
    nvec++; if (imem_addr_out !== 32'h4) begin nerr++; $display("FAIL zw_addr2 got %h want 4", imem_addr_out); end
    cyc();
    nvec++; if (inst_out !== 32'h20020007) begin nerr++; $display("FAIL zw_inst3 got %h want 20020007", inst_out); end
    nvec++; if (npc_out !== 32'h8) begin nerr++; $display("FAIL zw_npc3 got %h want 8", npc_out); end
    nvec++; if (imem_addr_out !== 32'h8) begin nerr++; $display("FAIL zw_addr3 got %h want 8", imem_addr_out); end
    cyc();
    nvec++; if (inst_out !== 32'h00221820) begin nerr++; $display("FAIL zw_inst4 got %h want 00221820", inst_out); end
    nvec++; if (npc_out !== 32'hC) begin nerr++; $display("FAIL zw_npc4 got %h want c", npc_out); end
    nvec++; if (inst_valid_out !== 1'b1) begin nerr++; $display("FAIL zw_valid4 got %b want 1", inst_valid_out); end
  endtask

  task automatic test_wait_states();
    logic [4:0] exp_valid;
    mem_wait = 3;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      cyc();
      nvec++; if (imem_req_out !== 1'b1) begin nerr++; $display("FAIL ws_req c%0d got %b want 1", c, imem_req_out); end
      nvec++; if (imem_addr_out !== 32'h0) begin nerr++; $display("FAIL ws_addr c%0d got %h want 0", c, imem_addr_out); end
      nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL ws_valid c%0d got %b want 0", c, inst_valid_out); end
    end
    exp_valid = 5'b10001;  // bit4 = cycle 5 ... bit0 = cycle 9
    for (int c = 5; c <= 9; c++) begin
      cyc();
      nvec++; if (inst_valid_out !== exp_valid[9-c]) begin nerr++; $display("FAIL ws_valid c%0d got %b want %b", c, inst_valid_out, exp_valid[9-c]); end
    end
    nvec++; if (npc_out !== 32'h8) begin nerr++; $display("FAIL ws_npc c9 got %h want 8", npc_out); end
    nvec++; if (inst_out !== 32'h20020007) begin nerr++; $display("FAIL ws_inst c9 got %h want 20020007", inst_out); end
  endtask

  task automatic test_stall_skid();
    mem_wait = 0;
    apply_reset();
    cyc(); cyc();          // c2: addr-0 word valid, addr 4 completing
    stall_in = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      cyc();
      nvec++; if (imem_req_out !== 1'b0) begin nerr++; $display("FAIL sk_req c%0d got %b want 0", c, imem_req_out); end
      nvec++; if (inst_out !== 32'h20010005) begin nerr++; $display("FAIL sk_inst c%0d got %h want 20010005", c, inst_out); end
      nvec++; if (npc_out !== 32'h4 || inst_valid_out !== 1'b1) begin nerr++; $display("FAIL sk_npc c%0d got %h/%b want 4/1", c, npc_out, inst_valid_out); end
    end
    cyc();                 // c7: still buffered, release now
    stall_in = 1'b0;
    cyc();
    nvec++; if (inst_out !== 32'h20020007) begin nerr++; $display("FAIL sk_rel_inst got %h want 20020007", inst_out); end
    nvec++; if (npc_out !== 32'h8) begin nerr++; $display("FAIL sk_rel_npc got %h want 8", npc_out); end
    nvec++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin nerr++; $display("FAIL sk_resume got %b/%h want 1/8", imem_req_out, imem_addr_out); end
    cyc();
    nvec++; if (inst_out !== 32'h00221820 || npc_out !== 32'hC) begin nerr++; $display("FAIL sk_next got %h/%h want 00221820/c", inst_out, npc_out); end
  endtask

  task automatic test_jump_drain();
    mem_wait = 0;
    apply_reset();
    cyc(); cyc(); cyc(); cyc();   // c4: addr C completing
    mem_wait = 2;
    cyc();                        // c5: request to 0x10 pending
    nvec++; if (imem_addr_out !== 32'h10 || npc_out !== 32'h10) begin nerr++; $display("FAIL jd_pre got %h/%h want 10/10", imem_addr_out, npc_out); end
    jmp_inst_in = 1'b1; new_pc_in = 32'h100;
    cyc();
    jmp_inst_in = 1'b0; new_pc_in = '0;
    for (int c = 6; c <= 7; c++) begin
      nvec++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h10) begin nerr++; $display("FAIL jd_hold c%0d got %b/%h want 1/10", c, imem_req_out, imem_addr_out); end
      nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL jd_valid c%0d got %b want 0", c, inst_valid_out); end
      cyc();
    end
    nvec++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin nerr++; $display("FAIL jd_target got %b/%h want 1/100", imem_req_out, imem_addr_out); end
    nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL jd_valid c8 got %b want 0", inst_valid_out); end
  endtask

  task automatic test_redirect_ready_buffered();
    mem_wait = 0;
    apply_reset();
    cyc(); cyc();                 // c2: addr 4 completing
    branch_taken_in = 1'b1; new_pc_in = 32'h40;
    cyc();
    branch_taken_in = 1'b0; new_pc_in = '0;
    nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL rr_flush got %b want 0", inst_valid_out); end
    nvec++; if (imem_addr_out !== 32'h40 || imem_req_out !== 1'b1) begin nerr++; $display("FAIL rr_addr got %b/%h want 1/40", imem_req_out, imem_addr_out); end
    cyc();                        // c4: 0x40 word valid, 0x44 completing
    nvec++; if (inst_valid_out !== 1'b1 || npc_out !== 32'h44) begin nerr++; $display("FAIL rr_first got %b/%h want 1/44", inst_valid_out, npc_out); end
    stall_in = 1'b1;
    cyc();                        // c5: 0x44 word in skid buffer
    nvec++; if (imem_req_out !== 1'b0) begin nerr++; $display("FAIL rb_req got %b want 0", imem_req_out); end
    jmp_inst_in = 1'b1; new_pc_in = 32'h40;
    cyc();
    jmp_inst_in = 1'b0; new_pc_in = '0; stall_in = 1'b0;
    nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL rb_flush got %b want 0", inst_valid_out); end
    nvec++; if (imem_addr_out !== 32'h40 || imem_req_out !== 1'b1) begin nerr++; $display("FAIL rb_addr got %b/%h want 1/40", imem_req_out, imem_addr_out); end
    cyc();
    nvec++; if (inst_out !== (32'h40 ^ 32'hDEAD0000) || npc_out !== 32'h44) begin nerr++; $display("FAIL rb_out got %h/%h want dead0040/44", inst_out, npc_out); end
  endtask

  task automatic test_reset_mid_drain();
    mem_wait = 0;
    apply_reset();
    cyc(); cyc();                 // c2: addr 4 completing
    mem_wait = 3;
    cyc();                        // c3: addr 8 pending
    jmp_inst_in = 1'b1; new_pc_in = 32'h80;
    cyc();                        // c4: in DRAIN
    jmp_inst_in = 1'b0; new_pc_in = '0;
    nvec++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin nerr++; $display("FAIL md_drain got %b/%h want 1/8", imem_req_out, imem_addr_out); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (imem_req_out !== 1'b0) begin nerr++; $display("FAIL md_req got %b want 0", imem_req_out); end
    nvec++; if (imem_addr_out !== 32'h0) begin nerr++; $display("FAIL md_addr got %h want 0", imem_addr_out); end
    nvec++; if (inst_out !== 32'h0 || npc_out !== 32'h0) begin nerr++; $display("FAIL md_out got %h/%h want 0/0", inst_out, npc_out); end
    nvec++; if (inst_valid_out !== 1'b0) begin nerr++; $display("FAIL md_valid got %b want 0", inst_valid_out); end
  endtask

  task automatic test_pc_wrap();
    mem_wait = 0;
    apply_reset();
    cyc();                        // c1: addr 0 completing
    jmp_inst_in = 1'b1; new_pc_in = 32'hFFFFFFFC;
    cyc();
    jmp_inst_in = 1'b0; new_pc_in = '0;
    nvec++; if (imem_addr_out !== 32'hFFFFFFFC) begin nerr++; $display("FAIL wr_addr got %h want fffffffc", imem_addr_out); end
    cyc();
    nvec++; if (npc_out !== 32'h0 || inst_valid_out !== 1'b1) begin nerr++; $display("FAIL wr_npc got %h/%b want 0/1", npc_out, inst_valid_out); end
    nvec++; if (inst_out !== 32'h2152FFFC) begin nerr++; $display("FAIL wr_inst got %h want 2152fffc", inst_out); end
    nvec++; if (imem_addr_out !== 32'h0) begin nerr++; $display("FAIL wr_next got %h want 0", imem_addr_out); end
    cyc();
    nvec++; if (inst_out !== 32'h20010005 || npc_out !== 32'h4) begin nerr++; $display("FAIL wr_after got %h/%h want 20010005/4", inst_out, npc_out); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_stall_skid();
    test_jump_drain();
    test_redirect_ready_buffered();
    test_reset_mid_drain();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
